// File: rtl/graphene_cam_tracker.sv
// graphene_cam_tracker: search/write initiator for the Graphene hot-row CAM.
// Keeps one Misra-Gries counter per CAM entry plus a spillover counter.
// Each accepted row key is searched in the CAM. A hit bumps that entry's counter.
// A miss replaces the lowest entry whose count equals the spillover value,
// or bumps the spillover counter when no such entry exists.
// Optional feature macro: TRACKER_STATS_EN adds hit/miss/replace statistics.
module graphene_cam_tracker #(
   parameter int WORD_SIZE   = 16,
   parameter int ENTRY_WIDTH = 7,
   parameter int ROW_NUM     = 68,
   parameter int COUNT_WIDTH = 16,
   parameter logic [COUNT_WIDTH-1:0] THRESHOLD = 16'd1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WORD_SIZE-1:0]   req_key,
   input  logic                   win_reset,
   output logic                   hot_valid,
   output logic [WORD_SIZE-1:0]   hot_key,
   output logic [COUNT_WIDTH-1:0] spill_count,
   output logic [WORD_SIZE-1:0]   cam_data_in,
   output logic [ENTRY_WIDTH-1:0] cam_addr_in,
   output logic                   cam_read_en,
   output logic                   cam_write_en,
   output logic                   cam_search_en,
   output logic                   cam_reset,
   input  logic                   cam_match,
   input  logic [ENTRY_WIDTH-1:0] cam_addr_out
`ifdef TRACKER_STATS_EN
   ,
   output logic [COUNT_WIDTH-1:0] stat_hits,
   output logic [COUNT_WIDTH-1:0] stat_misses,
   output logic [COUNT_WIDTH-1:0] stat_replaces
`endif
);

   typedef enum logic [2:0] {IDLE, SRCH, EVAL, WR, CLR} state_t;

   state_t                 state_reg;
   logic [WORD_SIZE-1:0]   key_reg;
   logic [COUNT_WIDTH-1:0] cnt_reg [ROW_NUM];
   logic [COUNT_WIDTH-1:0] spill_reg;
   logic [ENTRY_WIDTH-1:0] cand_reg;
   logic                   cam_reset_reg;

   logic [ROW_NUM-1:0]     cand_hit;
   logic                   cand_any;
   logic [ENTRY_WIDTH-1:0] cand_idx;
   logic                   hit_ok;
   logic                   upd_en;
   logic [ENTRY_WIDTH-1:0] upd_idx;
   logic [COUNT_WIDTH-1:0] upd_old;
   logic [COUNT_WIDTH-1:0] upd_new;
   logic                   hot_fire;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign req_ready   = (state_reg == IDLE) && !win_reset;
   assign cam_read_en = 1'b0;
   // The CAM is also held in reset for as long as the tracker is.
   assign cam_reset   = cam_reset_reg | reset;
   assign spill_count = spill_reg;

   // An entry is a replacement candidate when its count equals the spillover value.
   generate
      for (genvar gi = 0; gi < ROW_NUM; gi++) begin : g_cand
         assign cand_hit[gi] = (cnt_reg[gi] == spill_reg);
      end
   endgenerate

   // Priority-select the lowest candidate index.
   always_comb begin
      cand_idx = '0;
      for (int i = ROW_NUM - 1; i >= 0; i--) begin
         if (cand_hit[i]) cand_idx = ENTRY_WIDTH'(i);
      end
   end
   assign cand_any = |cand_hit;

   // The CAM result is sampled live in EVAL: it appears one cycle after the search.
   assign hit_ok = cam_match && (cam_addr_out < ENTRY_WIDTH'(ROW_NUM));

   // Select the single counter update of this cycle: hit increment or replacement install.
   always_comb begin
      upd_en  = 1'b0;
      upd_idx = '0;
      upd_old = '0;
      if (state_reg == EVAL && hit_ok) begin
         upd_en  = 1'b1;
         upd_idx = cam_addr_out;
         upd_old = cnt_reg[cam_addr_out];
      end else if (state_reg == WR) begin
         upd_en  = 1'b1;
         upd_idx = cand_reg;
         upd_old = spill_reg;
      end
   end
   assign upd_new  = sat_inc(upd_old);
   // A saturated count does not change, so it can never re-fire.
   assign hot_fire = upd_en && (upd_new == THRESHOLD) && (upd_new != upd_old);

   // Control FSM with registered CAM controls and hot event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         key_reg       <= '0;
         cand_reg      <= '0;
         cam_search_en <= 1'b0;
         cam_write_en  <= 1'b0;
         cam_addr_in   <= '0;
         cam_data_in   <= '0;
         cam_reset_reg <= 1'b0;
         hot_valid     <= 1'b0;
         hot_key       <= '0;
      end else begin
         cam_search_en <= 1'b0;
         cam_write_en  <= 1'b0;
         cam_addr_in   <= '0;
         cam_data_in   <= '0;
         cam_reset_reg <= 1'b0;
         hot_valid     <= 1'b0;
         if (win_reset) begin
            // Drop whatever is in flight and clear the CAM next cycle.
            state_reg     <= CLR;
            cam_reset_reg <= 1'b1;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (req_valid) begin
                     key_reg       <= req_key;
                     cam_search_en <= 1'b1;
                     cam_data_in   <= req_key;
                     state_reg     <= SRCH;
                  end
               end
               SRCH: state_reg <= EVAL;
               EVAL: begin
                  if (!hit_ok && cand_any) begin
                     cam_write_en <= 1'b1;
                     cam_addr_in  <= cand_idx;
                     cam_data_in  <= key_reg;
                     cand_reg     <= cand_idx;
                     state_reg    <= WR;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
               default: state_reg <= IDLE;
            endcase
            if (hot_fire) begin
               hot_valid <= 1'b1;
               hot_key   <= key_reg;
            end
         end
      end
   end

   // Entry counters and spillover counter; a window reset clears them all.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROW_NUM; i++) cnt_reg[i] <= '0;
         spill_reg <= '0;
      end else if (win_reset) begin
         for (int i = 0; i < ROW_NUM; i++) cnt_reg[i] <= '0;
         spill_reg <= '0;
      end else begin
         if (upd_en) cnt_reg[upd_idx] <= upd_new;
         if (state_reg == EVAL && !hit_ok && !cand_any) spill_reg <= sat_inc(spill_reg);
      end
   end

`ifdef TRACKER_STATS_EN
   // Outcome statistics, counted when each outcome is decided.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_hits     <= '0;
         stat_misses   <= '0;
         stat_replaces <= '0;
      end else if (win_reset) begin
         stat_hits     <= '0;
         stat_misses   <= '0;
         stat_replaces <= '0;
      end else begin
         if (state_reg == EVAL && hit_ok)  stat_hits     <= sat_inc(stat_hits);
         if (state_reg == EVAL && !hit_ok) stat_misses   <= sat_inc(stat_misses);
         if (state_reg == WR)              stat_replaces <= sat_inc(stat_replaces);
      end
   end
`endif

endmodule

// File: tb/tb_graphene_cam_tracker.sv
// Testbench for graphene_cam_tracker, with a behavioural CAM model attached.
module tb_graphene_cam_tracker;
   localparam int WS = 16, EW = 7, RN = 68, CW = 16;

   logic          clk = 1'b0;
   logic          reset, req_valid, req_ready, win_reset, hot_valid;
   logic [WS-1:0] req_key, hot_key, cam_data_in;
   logic [CW-1:0] spill_count;
   logic [EW-1:0] cam_addr_in, cam_addr_out;
   logic          cam_read_en, cam_write_en, cam_search_en, cam_reset, cam_match;
`ifdef TRACKER_STATS_EN
   logic [CW-1:0] stat_hits, stat_misses, stat_replaces;
`endif

   graphene_cam_tracker dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_key(req_key), .win_reset(win_reset), .hot_valid(hot_valid), .hot_key(hot_key),
      .spill_count(spill_count), .cam_data_in(cam_data_in), .cam_addr_in(cam_addr_in),
      .cam_read_en(cam_read_en), .cam_write_en(cam_write_en), .cam_search_en(cam_search_en),
      .cam_reset(cam_reset), .cam_match(cam_match), .cam_addr_out(cam_addr_out)
`ifdef TRACKER_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_replaces(stat_replaces)
`endif
   );

   always #5 clk = ~clk;

   // CAM model: registered search returning the lowest matching index.
   logic [WS-1:0] cam_mem [RN];
   always @(posedge clk) begin
      automatic logic          found = 1'b0;
      automatic logic [EW-1:0] fidx  = '0;
      if (cam_reset) begin
         for (int i = 0; i < RN; i++) cam_mem[i] <= '0;
         cam_match    <= 1'b0;
         cam_addr_out <= '0;
      end else begin
         if (cam_write_en) cam_mem[cam_addr_in] <= cam_data_in;
         if (cam_search_en) begin
            for (int i = RN - 1; i >= 0; i--) begin
               if (cam_mem[i] == cam_data_in) begin
                  found = 1'b1;
                  fidx  = EW'(i);
               end
            end
         end
         cam_match    <= found;
         cam_addr_out <= fidx;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Results of the last transaction.
   int            r_lat;
   logic          r_wr, r_hot, r_srch, r_both;
   logic [EW-1:0] r_addr;
   logic [WS-1:0] r_data, r_hkey;

   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         if (req_ready) return;
         @(negedge clk);
      end
      chk("ready_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   // Called and returns on a falling edge; observes the whole transaction.
   task automatic send(input logic [WS-1:0] key);
      wait_ready();
      req_valid = 1'b1;
      req_key   = key;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      r_lat = 99; r_wr = 0; r_hot = 0; r_srch = 0; r_both = 0;
      r_addr = '0; r_data = '0; r_hkey = '0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 1 && cam_search_en && cam_data_in == key) r_srch = 1'b1;
         if (cam_search_en && cam_write_en) r_both = 1'b1;
         if (cam_write_en) begin
            r_wr = 1'b1; r_addr = cam_addr_in; r_data = cam_data_in;
         end
         if (hot_valid) begin
            r_hot = 1'b1; r_hkey = hot_key;
         end
         if (req_ready) begin
            r_lat = c;
            break;
         end
         @(negedge clk);
      end
      $display("txn key=%h lat=%0d wr=%0d addr=%0d hot=%0d spill=%0d",
               key, r_lat, r_wr, r_addr, r_hot, spill_count);
   endtask

   task automatic win_pulse(input logic [CW-1:0] spill_before);
      win_reset = 1'b1;
      #1;
      chk("ready_in_win_cycle", {31'd0, req_ready}, 32'd0);
      chk("spill_before_win", {16'd0, spill_count}, {16'd0, spill_before});
      @(negedge clk);
      win_reset = 1'b0;
      chk("cam_reset_pulse", {31'd0, cam_reset}, 32'd1);
      chk("ready_in_clr_cycle", {31'd0, req_ready}, 32'd0);
      chk("spill_cleared", {16'd0, spill_count}, 32'd0);
      @(negedge clk);
      chk("cam_reset_one_cycle", {31'd0, cam_reset}, 32'd0);
      chk("ready_after_clr", {31'd0, req_ready}, 32'd1);
   endtask

   typedef struct {
      logic [WS-1:0] key;
      logic          exp_wr;
      logic [EW-1:0] exp_addr;
      int            exp_lat;
      logic [CW-1:0] exp_spill;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int hot_cnt, hot_at, bad_lat, bad_fill;
      logic [WS-1:0] last_hkey;

      vecs[0] = '{16'h0A5A, 1'b1, 7'd0, 4, 16'd0}; // miss, install at 0
      vecs[1] = '{16'h0A5A, 1'b0, 7'd0, 3, 16'd0}; // hit idx 0
      vecs[2] = '{16'h1234, 1'b1, 7'd1, 4, 16'd0}; // miss, lowest cnt==0 is 1
      vecs[3] = '{16'h1234, 1'b0, 7'd0, 3, 16'd0}; // hit idx 1
      vecs[4] = '{16'h0000, 1'b0, 7'd0, 3, 16'd0}; // key 0 hits cleared entry 2
      vecs[5] = '{16'h5555, 1'b1, 7'd3, 4, 16'd0}; // miss, entries 0..2 nonzero

      reset = 1'b1; req_valid = 1'b0; req_key = '0; win_reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cam_reset", {31'd0, cam_reset}, 32'd1);
      chk("rst_spill", {16'd0, spill_count}, 32'd0);
      chk("rst_hot", {31'd0, hot_valid}, 32'd0);
      chk("rst_search_en", {31'd0, cam_search_en}, 32'd0);
      chk("rst_write_en", {31'd0, cam_write_en}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_cam_reset", {31'd0, cam_reset}, 32'd0);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("read_en_tied", {31'd0, cam_read_en}, 32'd0);

      // Table-driven basic hit / replace behaviour.
      foreach (vecs[i]) begin
         send(vecs[i].key);
         chk($sformatf("v%0d_lat", i), r_lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_search", i), {31'd0, r_srch}, 32'd1);
         chk($sformatf("v%0d_excl", i), {31'd0, r_both}, 32'd0);
         chk($sformatf("v%0d_wr", i), {31'd0, r_wr}, {31'd0, vecs[i].exp_wr});
         if (vecs[i].exp_wr) begin
            chk($sformatf("v%0d_addr", i), {25'd0, r_addr}, {25'd0, vecs[i].exp_addr});
            chk($sformatf("v%0d_data", i), {16'd0, r_data}, {16'd0, vecs[i].key});
         end
         chk($sformatf("v%0d_spill", i), {16'd0, spill_count}, {16'd0, vecs[i].exp_spill});
         chk($sformatf("v%0d_hot", i), {31'd0, r_hot}, 32'd0);
      end

      win_pulse(16'd0);

      // Install, then 1023 hits: the 1024th access fires hot exactly once.
      send(16'h0A5A);
      chk("t1_wr", {31'd0, r_wr}, 32'd1);
      chk("t1_addr", {25'd0, r_addr}, 32'd0);
      chk("t1_lat", r_lat, 4);
      hot_cnt = 0; hot_at = -1; bad_lat = 0; last_hkey = '0;
      for (int n = 0; n < 1023; n++) begin
         send(16'h0A5A);
         if (r_lat != 3 || r_wr) bad_lat++;
         if (r_hot) begin
            hot_cnt++; hot_at = n; last_hkey = r_hkey;
         end
      end
      chk("t2_hit_lat", bad_lat, 0);
      chk("t2_hot_count", hot_cnt, 1);
      chk("t2_hot_at", hot_at, 1022);
      chk("t2_hot_key", {16'd0, last_hkey}, 32'h0A5A);
`ifdef TRACKER_STATS_EN
      chk("t6_hits", {16'd0, stat_hits}, 32'd1023);
      chk("t6_misses", {16'd0, stat_misses}, 32'd1);
      chk("t6_replaces", {16'd0, stat_replaces}, 32'd1);
`endif
      send(16'h0A5A);
      chk("t2_no_refire", {31'd0, r_hot}, 32'd0);

      win_pulse(16'd0);

      // Fill every entry at count 1, then force spill and a replacement.
      bad_fill = 0;
      for (int i = 0; i < RN; i++) begin
         send(16'h1000 + 16'(i));
         if (!r_wr || r_addr != EW'(i) || r_lat != 4) bad_fill++;
      end
      chk("t3_fill", bad_fill, 0);
      send(16'h2000);
      chk("t3_lat", r_lat, 3);
      chk("t3_no_write", {31'd0, r_wr}, 32'd0);
      chk("t3_spill", {16'd0, spill_count}, 32'd1);
      send(16'h2001);
      chk("t4_wr", {31'd0, r_wr}, 32'd1);
      chk("t4_addr", {25'd0, r_addr}, 32'd0);
      chk("t4_spill", {16'd0, spill_count}, 32'd1);
      send(16'h2002); // entry 0 now at 2, so entry 1 is the candidate
      chk("t4_next_addr", {25'd0, r_addr}, 32'd1);

      // Window reset during SRCH drops the key.
      wait_ready();
      req_valid = 1'b1; req_key = 16'h3333;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t5_in_srch", {31'd0, cam_search_en}, 32'd1);
      win_reset = 1'b1;
      @(negedge clk);
      win_reset = 1'b0;
      chk("t5_cam_reset", {31'd0, cam_reset}, 32'd1);
      chk("t5_ready_low", {31'd0, req_ready}, 32'd0);
      chk("t5_spill_clr", {16'd0, spill_count}, 32'd0);
      chk("t5_no_write", {31'd0, cam_write_en}, 32'd0);
      @(negedge clk);
      chk("t5_cam_reset_end", {31'd0, cam_reset}, 32'd0);
      chk("t5_ready_back", {31'd0, req_ready}, 32'd1);
      chk("t5_no_hot", {31'd0, hot_valid}, 32'd0);
      chk("t5_no_write2", {31'd0, cam_write_en}, 32'd0);
      send(16'h4444);
      chk("t5_install_wr", {31'd0, r_wr}, 32'd1);
      chk("t5_install_addr", {25'd0, r_addr}, 32'd0);
      chk("t5_install_lat", r_lat, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
